// File: rtl/cpu_bus_bridge_pkg.sv
// Shared encodings for the CPU-to-fabric bus bridge.
// FSM states and CPU read/write direction codes.
package cpu_bus_bridge_pkg;

  localparam logic ENUM__CPU_WH_RDWR__READ  = 1'b0;
  localparam logic ENUM__CPU_WH_RDWR__WRITE = 1'b1;

  localparam int ENUM__CPU_BUS_ST__MSB_POS = 1;

  typedef enum logic [ENUM__CPU_BUS_ST__MSB_POS:0] {
    ENUM__CPU_BUS_ST__IDLE  = 2'd0,
    ENUM__CPU_BUS_ST__ISSUE = 2'd1,
    ENUM__CPU_BUS_ST__DONE  = 2'd2
  } cpu_bus_st_e;

endpackage

// File: rtl/cpu_bus_bridge_if.sv
// CPU request side plus memory valid/ack side of the bridge.
// master: bridge view; slave: CPU + fabric view.
interface cpu_bus_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  cpu_req_rdwr;
  logic                  cpu_which_rdwr;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data_out;
  logic                  cpu_enable;
  logic [DATA_WIDTH-1:0] cpu_data_in;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  bus_err;
  logic [7:0]            err_count;

  modport master (
    input  cpu_req_rdwr, cpu_which_rdwr,
    input  cpu_addr, cpu_data_out,
    input  mem_ack, mem_rdata,
    output cpu_enable, cpu_data_in,
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    output bus_err, err_count
  );

  modport slave (
    output cpu_req_rdwr, cpu_which_rdwr,
    output cpu_addr, cpu_data_out,
    output mem_ack, mem_rdata,
    input  cpu_enable, cpu_data_in,
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    input  bus_err, err_count
  );
endinterface

// File: rtl/cpu_bus_bridge.sv
// Turns CPU rd/wr requests into valid/ack bus cycles, stalling the CPU.
// Ports: clk, rst (async, active-low), bus (cpu_* and mem_* signals).
module cpu_bus_bridge
  import cpu_bus_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA =
    DATA_WIDTH'(8'hFF)
) (
  input logic               clk,
  input logic               rst,
  cpu_bus_bridge_if.master  bus
);

  localparam logic [7:0] TO_LAST =
    8'(TIMEOUT_CYCLES - 1);

  cpu_bus_st_e           state_q;
  cpu_bus_st_e           state_d;
  logic [7:0]            cnt_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [7:0]            err_cnt_q;
  logic                  to_hit;
  logic                  is_idle;
  logic                  is_issue;
  logic                  is_done;

  assign is_idle  = state_q == ENUM__CPU_BUS_ST__IDLE;
  assign is_issue = state_q == ENUM__CPU_BUS_ST__ISSUE;
  assign is_done  = state_q == ENUM__CPU_BUS_ST__DONE;
  assign to_hit   = cnt_q == TO_LAST;

  assign bus.cpu_enable =
    (is_idle && !bus.cpu_req_rdwr) || is_done;
  assign bus.mem_req     = is_issue;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.cpu_data_in = rdata_q;
  assign bus.bus_err     = err_q;
  assign bus.err_count   = err_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      is_idle:
        if (bus.cpu_req_rdwr)
          state_d = ENUM__CPU_BUS_ST__ISSUE;
      is_issue:
        if (bus.mem_ack || to_hit)
          state_d = ENUM__CPU_BUS_ST__DONE;
      is_done:
        state_d = ENUM__CPU_BUS_ST__IDLE;
      default:
        state_d = ENUM__CPU_BUS_ST__IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ENUM__CPU_BUS_ST__IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack is checked before the timeout so a coincident ack wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (is_idle && bus.cpu_req_rdwr) begin
        addr_q  <= bus.cpu_addr;
        wdata_q <= bus.cpu_data_out;
        we_q    <= bus.cpu_which_rdwr;
        cnt_q   <= '0;
      end else if (is_issue) begin
        if (bus.mem_ack) begin
          if (we_q == ENUM__CPU_WH_RDWR__READ)
            rdata_q <= bus.mem_rdata;
        end else if (to_hit) begin
          if (we_q == ENUM__CPU_WH_RDWR__READ)
            rdata_q <= ERR_DATA;
          err_q <= 1'b1;
          if (err_cnt_q != 8'hFF)
            err_cnt_q <= err_cnt_q + 8'd1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cpu_bus_bridge.sv
// Directed bench for cpu_bus_bridge with TIMEOUT_CYCLES=4.
// Drives and samples on the falling edge.
module tb_cpu_bus_bridge;
  import cpu_bus_bridge_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   n;

  always #5 clk = ~clk;

  cpu_bus_bridge_if #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8)
  ) bif ();

  cpu_bus_bridge #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(4),
    .ERR_DATA(8'hFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif.master)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // Called at a falling edge in IDLE; returns at the
  // falling edge inside DONE with req dropped.
  // dly<0 means no ack at all.
  task automatic xfer(
    input  logic        we,
    input  logic [15:0] a,
    input  logic [7:0]  d,
    input  int          dly,
    input  logic [7:0]  rd,
    output int          ncyc
  );
    bif.cpu_req_rdwr   = 1'b1;
    bif.cpu_which_rdwr = we;
    bif.cpu_addr       = a;
    bif.cpu_data_out   = d;
    #1;
    chk("en_req", 32'(bif.cpu_enable), 32'd0);
    ncyc = 0;
    @(negedge clk);
    while (bif.mem_req && ncyc < 300) begin
      ncyc++;
      chk("addr", 32'(bif.mem_addr), 32'(a));
      chk("we", 32'(bif.mem_we), 32'(we));
      chk("wdata", 32'(bif.mem_wdata), 32'(d));
      chk("en_stall", 32'(bif.cpu_enable), 32'd0);
      bif.cpu_addr       = ~a;
      bif.cpu_data_out   = ~d;
      bif.cpu_which_rdwr = ~we;
      bif.mem_ack        = (ncyc - 1 == dly);
      bif.mem_rdata      = rd;
      @(negedge clk);
    end
    bif.mem_ack = 1'b0;
    chk("en_done", 32'(bif.cpu_enable), 32'd1);
    chk("req_done", 32'(bif.mem_req), 32'd0);
    bif.cpu_req_rdwr = 1'b0;
  endtask

  initial begin
    bif.cpu_req_rdwr   = 1'b0;
    bif.cpu_which_rdwr = 1'b0;
    bif.cpu_addr       = '0;
    bif.cpu_data_out   = '0;
    bif.mem_ack        = 1'b0;
    bif.mem_rdata      = '0;

    @(negedge clk);
    chk("rst_req", 32'(bif.mem_req), 32'd0);
    chk("rst_addr", 32'(bif.mem_addr), 32'd0);
    chk("rst_rdata", 32'(bif.cpu_data_in), 32'd0);
    chk("rst_errc", 32'(bif.err_count), 32'd0);
    chk("rst_berr", 32'(bif.bus_err), 32'd0);
    chk("rst_en", 32'(bif.cpu_enable), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    xfer(ENUM__CPU_WH_RDWR__READ, 16'h1234,
         8'h00, 0, 8'hA5, n);
    chk("t1_len", 32'(n), 32'd1);
    chk("t1_data", 32'(bif.cpu_data_in), 32'hA5);
    chk("t1_berr", 32'(bif.bus_err), 32'd0);
    @(negedge clk);
    chk("t1_idle_en", 32'(bif.cpu_enable), 32'd1);

    xfer(ENUM__CPU_WH_RDWR__WRITE, 16'h00FF,
         8'h5A, 3, 8'h11, n);
    chk("t2_len", 32'(n), 32'd4);
    chk("t2_data", 32'(bif.cpu_data_in), 32'hA5);
    @(negedge clk);

    xfer(ENUM__CPU_WH_RDWR__READ, 16'h2000,
         8'h00, -1, 8'h22, n);
    chk("t3_len", 32'(n), 32'd4);
    chk("t3_data", 32'(bif.cpu_data_in), 32'hFF);
    chk("t3_berr", 32'(bif.bus_err), 32'd1);
    chk("t3_errc", 32'(bif.err_count), 32'd1);
    @(negedge clk);
    chk("t3_berr_off", 32'(bif.bus_err), 32'd0);

    xfer(ENUM__CPU_WH_RDWR__READ, 16'h0010,
         8'h00, 1, 8'h3C, n);
    chk("t4a_len", 32'(n), 32'd2);
    chk("t4a_data", 32'(bif.cpu_data_in), 32'h3C);
    bif.cpu_req_rdwr   = 1'b1;
    bif.cpu_which_rdwr = ENUM__CPU_WH_RDWR__WRITE;
    bif.cpu_addr       = 16'h0020;
    bif.cpu_data_out   = 8'hC3;
    @(negedge clk);
    chk("t4_idle_req", 32'(bif.mem_req), 32'd0);
    chk("t4_idle_en", 32'(bif.cpu_enable), 32'd0);
    xfer(ENUM__CPU_WH_RDWR__WRITE, 16'h0020,
         8'hC3, 0, 8'h44, n);
    chk("t4b_len", 32'(n), 32'd1);
    chk("t4b_data", 32'(bif.cpu_data_in), 32'h3C);
    @(negedge clk);

    bif.mem_ack   = 1'b1;
    bif.mem_rdata = 8'h77;
    @(negedge clk);
    chk("t5_req", 32'(bif.mem_req), 32'd0);
    chk("t5_data", 32'(bif.cpu_data_in), 32'h3C);
    chk("t5_en", 32'(bif.cpu_enable), 32'd1);
    bif.mem_ack = 1'b0;
    @(negedge clk);
    chk("t5_req2", 32'(bif.mem_req), 32'd0);

    xfer(ENUM__CPU_WH_RDWR__READ, 16'h3000,
         8'h00, 3, 8'h42, n);
    chk("t6_len", 32'(n), 32'd4);
    chk("t6_data", 32'(bif.cpu_data_in), 32'h42);
    chk("t6_berr", 32'(bif.bus_err), 32'd0);
    chk("t6_errc", 32'(bif.err_count), 32'd1);
    @(negedge clk);

    bif.cpu_req_rdwr   = 1'b1;
    bif.cpu_which_rdwr = ENUM__CPU_WH_RDWR__READ;
    bif.cpu_addr       = 16'h4444;
    @(negedge clk);
    chk("t7_issue", 32'(bif.mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t7_req", 32'(bif.mem_req), 32'd0);
    chk("t7_addr", 32'(bif.mem_addr), 32'd0);
    chk("t7_we", 32'(bif.mem_we), 32'd0);
    chk("t7_data", 32'(bif.cpu_data_in), 32'd0);
    chk("t7_errc", 32'(bif.err_count), 32'd0);
    bif.cpu_req_rdwr = 1'b0;
    #1;
    chk("t7_en", 32'(bif.cpu_enable), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    xfer(ENUM__CPU_WH_RDWR__READ, 16'h5555,
         8'h00, 0, 8'h99, n);
    chk("t7_len", 32'(n), 32'd1);
    chk("t7_rd", 32'(bif.cpu_data_in), 32'h99);
    chk("t7_berr", 32'(bif.bus_err), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 255; i++) begin
      xfer(ENUM__CPU_WH_RDWR__READ, 16'h6000,
           8'h00, -1, 8'h00, n);
      @(negedge clk);
    end
    chk("t8_errc", 32'(bif.err_count), 32'd255);
    xfer(ENUM__CPU_WH_RDWR__READ, 16'h6001,
         8'h00, -1, 8'h00, n);
    chk("t8_len", 32'(n), 32'd4);
    chk("t8_berr", 32'(bif.bus_err), 32'd1);
    chk("t8_sat", 32'(bif.err_count), 32'd255);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_bridge.md
Name: cpu_bus_bridge

Overview:
- Sits directly downstream of the Cpu core, between it and the memory/peripheral fabric.
- Consumes the CPU's req_rdwr / which_rdwr / addr / data_out request and turns it into a valid/ack memory transaction.
- Stalls the CPU through its enable input until the transaction completes.
- Returns registered read data on cpu_data_in. A timeout aborts hung transactions and flags a bus error.

Parameters:
ADDR_WIDTH, 16, CPU/memory address width (16-bit absolute space for now)
DATA_WIDTH, 8, data bus width
TIMEOUT_CYCLES, 255, cycles in ISSUE without mem_ack before abort (1..255)
ERR_DATA, 8'hFF, read data returned on timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
cpu_req_rdwr  in  1  CPU requests an access
cpu_which_rdwr  in  1  0 = read (ENUM__CPU_WH_RDWR__READ), 1 = write (ENUM__CPU_WH_RDWR__WRITE)
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_data_out  in  DATA_WIDTH  CPU write data
cpu_enable  out  1  drives Cpu.enable; combinational
cpu_data_in  out  DATA_WIDTH  registered read data to Cpu.data_in
mem_req  out  1  transaction valid
mem_we  out  1  1 = write
mem_addr  out  ADDR_WIDTH  latched address
mem_wdata  out  DATA_WIDTH  latched write data
mem_ack  in  1  fabric completes the transaction this cycle
mem_rdata  in  DATA_WIDTH  read data, valid when mem_ack=1
bus_err  out  1  one-cycle pulse on timeout abort
err_count  out  8  saturating count of timeouts

Behaviour:
- Reset (rst=0, async, takes effect immediately):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_data_in=0x00, bus_err=0, err_count=0, timeout counter=0
  - Reset mid-transaction abandons it; mem_req falls without waiting for ack.
- cpu_enable = (state==IDLE && !cpu_req_rdwr) || state==DONE. The CPU is frozen from the cycle it raises req_rdwr until the DONE cycle, where it advances exactly once.
- FSM states:
  - IDLE: if cpu_req_rdwr=1, latch cpu_addr→mem_addr, cpu_data_out→mem_wdata, cpu_which_rdwr→mem_we; clear timeout counter; go to ISSUE. Otherwise stay.
  - ISSUE: mem_req=1, outputs held stable.
    - If mem_ack=1: for reads, cpu_data_in<=mem_rdata; go to DONE.
    - Else if counter==TIMEOUT_CYCLES-1: for reads, cpu_data_in<=ERR_DATA; bus_err<=1; err_count<=err_count+1, saturating at 255; go to DONE.
    - Else counter+1.
  - DONE: mem_req=0; bus_err high only if entered by timeout; go to IDLE unconditionally. A request the CPU raises at the DONE edge is seen in the following IDLE cycle.
- Latency: request in IDLE at cycle T, ack in the first ISSUE cycle → mem_req high at T+1, DONE at T+2, CPU sees data at the end of T+2. Each ack-delay cycle adds 1.
- mem_ack outside ISSUE is ignored.
- mem_ack and timeout in the same cycle: ack wins, no error.
- Writes never modify cpu_data_in; it holds the last read value.
- cpu_* inputs are ignored outside IDLE. The CPU holds them stable while stalled.
- TIMEOUT_CYCLES=1: abort after one ISSUE cycle unless ack arrives that cycle.
- err_count at 255 stays 255; bus_err still pulses.

Decomposition:
- Shared package/include (alongside cpu_enums): FSM state encodings (ENUM__CPU_BUS_ST__IDLE/ISSUE/DONE plus MSB-position define) and reuse of the existing ENUM__CPU_WH_RDWR__* encodings.
- No sub-module needed. An optional cpu_bus_timeout counter sub-module is acceptable; keep it inline unless it is reused.

Test Plan:
- Read, ack in first ISSUE cycle: addr=0x1234, mem_rdata=0xA5 → mem_req high exactly 1 cycle with mem_addr=0x1234, mem_we=0; cpu_data_in=0xA5 in DONE; cpu_enable pattern 0,0,1.
- Write, ack delayed 3 cycles: addr=0x00FF, data=0x5A → mem_req high 4 cycles, mem_we=1, mem_wdata=0x5A stable; cpu_data_in unchanged; cpu_enable low until DONE.
- Timeout, TIMEOUT_CYCLES=4, no ack, read: → mem_req high 4 cycles; DONE with cpu_data_in=0xFF; bus_err 1-cycle pulse; err_count=1.
- Back-to-back: second request raised at DONE edge → IDLE one cycle, then ISSUE; both transactions complete in order; cpu_addr changes during stall have no effect.
- Async reset asserted mid-ISSUE (between clock edges) → mem_req=0 immediately; all outputs at reset values; first request after release behaves as a fresh read.
- Spurious mem_ack while IDLE, plus ack coincident with the final timeout cycle → no state change on the spurious ack; the coincident case completes normally with bus_err=0 and err_count unchanged.
